// File: rtl/cyclic_decoder_systematic_if.sv
// Bit-serial link between the receive line and the (15,11) cyclic decoder.
// in_valid qualifies in_bit on each rising edge; there is no ready, and out_valid has no backpressure.
interface cyclic_decoder_systematic_if #(
   parameter int ERRCNT_W = 16
) ();
   logic                in_valid;
   logic                in_bit;
   logic                out_valid;
   logic                out_bit;
   logic                out_last;
   logic                blk_done;
   logic                err_flag;
   logic [3:0]          err_pos;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output in_valid, in_bit,
      input  out_valid, out_bit, out_last, blk_done, err_flag, err_pos, err_count
   );

   modport slave (
      input  in_valid, in_bit,
      output out_valid, out_bit, out_last, blk_done, err_flag, err_pos, err_count
   );
endinterface

// File: rtl/cyclic_decoder_systematic.sv
// Serial single-error-correcting decoder for the systematic (15,11) cyclic code, g(x) = x^4 + x + 1.
// Syndrome is built on the fly; the corrected word is shifted out MSB first on completion.
module cyclic_decoder_systematic #(
   parameter int OUT_PARITY = 0,
   parameter int ERRCNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   cyclic_decoder_systematic_if.slave  bus,
   output logic                        dbg_tx_state
);

   localparam logic [3:0] OUT_LEN  = (OUT_PARITY != 0) ? 4'd15 : 4'd11;
   localparam logic [3:0] OUT_LAST = OUT_LEN - 4'd1;

   typedef enum logic {TX_IDLE = 1'b0, TX_RUN = 1'b1} tx_state_t;

   tx_state_t           tx_state_q, tx_state_d;
   logic [3:0]          tx_cnt_q, tx_cnt_d;
   logic [14:0]         tx_sr_q, tx_sr_d;
   logic [3:0]          rx_cnt_q, rx_cnt_d;
   logic [3:0]          syn_q, syn_d;
   logic [14:0]         rx_buf_q, rx_buf_d;
   logic                out_valid_q, out_valid_d;
   logic                out_bit_q, out_bit_d;
   logic                out_last_q, out_last_d;
   logic                blk_done_q, blk_done_d;
   logic                err_flag_q, err_flag_d;
   logic [3:0]          err_pos_q, err_pos_d;
   logic [ERRCNT_W-1:0] err_count_q, err_count_d;

   logic [3:0]          syn_shift;
   logic [14:0]         buf_shift;
   logic [3:0]          pos;
   logic                syn_nz;
   logic [14:0]         corr_word;

   // Syndrome value s = x^i mod g(x) maps back to the erroneous bit index i.
   function automatic logic [3:0] syn_to_pos(input logic [3:0] s);
      logic [3:0] p;
      case (s)
         4'b0001: p = 4'd0;
         4'b0010: p = 4'd1;
         4'b0100: p = 4'd2;
         4'b1000: p = 4'd3;
         4'b0011: p = 4'd4;
         4'b0110: p = 4'd5;
         4'b1100: p = 4'd6;
         4'b1011: p = 4'd7;
         4'b0101: p = 4'd8;
         4'b1010: p = 4'd9;
         4'b0111: p = 4'd10;
         4'b1110: p = 4'd11;
         4'b1111: p = 4'd12;
         4'b1101: p = 4'd13;
         4'b1001: p = 4'd14;
         default: p = 4'd0;
      endcase
      return p;
   endfunction

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_cnt_d    = rx_cnt_q;
      syn_d       = syn_q;
      rx_buf_d    = rx_buf_q;
      out_valid_d = 1'b0;
      out_bit_d   = 1'b0;
      out_last_d  = 1'b0;
      blk_done_d  = 1'b0;
      err_flag_d  = err_flag_q;
      err_pos_d   = err_pos_q;
      err_count_d = err_count_q;

      syn_shift = {syn_q[2:0], bus.in_bit} ^ (syn_q[3] ? 4'b0011 : 4'b0000);
      buf_shift = {rx_buf_q[13:0], bus.in_bit};
      syn_nz    = (syn_shift != 4'b0000);
      pos       = syn_nz ? syn_to_pos(syn_shift) : 4'd0;
      corr_word = syn_nz ? (buf_shift ^ (15'd1 << pos)) : buf_shift;

      case (tx_state_q)
         TX_RUN: begin
            if (tx_cnt_q < OUT_LEN) begin
               out_valid_d = 1'b1;
               out_bit_d   = tx_sr_q[14];
               out_last_d  = (tx_cnt_q == OUT_LAST);
               tx_sr_d     = {tx_sr_q[13:0], 1'b0};
               tx_cnt_d    = tx_cnt_q + 4'd1;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      if (bus.in_valid) begin
         syn_d    = syn_shift;
         rx_buf_d = buf_shift;
         if (rx_cnt_q == 4'd14) begin
            rx_cnt_d   = 4'd0;
            syn_d      = 4'b0000;
            blk_done_d = 1'b1;
            err_flag_d = syn_nz;
            err_pos_d  = pos;
            if (syn_nz && (err_count_q != {ERRCNT_W{1'b1}}))
               err_count_d = err_count_q + ERRCNT_W'(1);
            // A load overrides the TX branch: the previous block has always finished by now.
            tx_state_d  = TX_RUN;
            out_valid_d = 1'b1;
            out_bit_d   = corr_word[14];
            out_last_d  = 1'b0;
            tx_sr_d     = {corr_word[13:0], 1'b0};
            tx_cnt_d    = 4'd1;
         end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= 4'd0;
         tx_sr_q     <= 15'd0;
         rx_cnt_q    <= 4'd0;
         syn_q       <= 4'b0000;
         rx_buf_q    <= 15'd0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
         blk_done_q  <= 1'b0;
         err_flag_q  <= 1'b0;
         err_pos_q   <= 4'd0;
         err_count_q <= '0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_cnt_q    <= rx_cnt_d;
         syn_q       <= syn_d;
         rx_buf_q    <= rx_buf_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
         blk_done_q  <= blk_done_d;
         err_flag_q  <= err_flag_d;
         err_pos_q   <= err_pos_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_bit    = out_bit_q;
   assign bus.out_last   = out_last_q;
   assign bus.blk_done   = blk_done_q;
   assign bus.err_flag   = err_flag_q;
   assign bus.err_pos    = err_pos_q;
   assign bus.err_count  = err_count_q;
   assign dbg_tx_state   = tx_state_q;

endmodule

// File: tb/tb_cyclic_decoder_systematic.sv
// Bench for the (15,11) cyclic decoder: one instance per output mode, fed the same serial input.
module tb_cyclic_decoder_systematic;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dbg0, dbg1;

   always #5 clk = ~clk;

   cyclic_decoder_systematic_if #(.ERRCNT_W(16)) bus0 ();
   cyclic_decoder_systematic_if #(.ERRCNT_W(16)) bus1 ();

   assign bus1.in_valid = bus0.in_valid;
   assign bus1.in_bit   = bus0.in_bit;

   cyclic_decoder_systematic #(.OUT_PARITY(0), .ERRCNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_tx_state(dbg0));
   cyclic_decoder_systematic #(.OUT_PARITY(1), .ERRCNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_tx_state(dbg1));

   int errors = 0;
   int checks = 0;
   int run1 = 0;
   int max_run1 = 0;

   logic [3:0]  pow_tab [15];
   logic [1:0]  exp_q0 [$];
   logic [1:0]  exp_q1 [$];
   logic [20:0] st_q0 [$];
   logic [20:0] st_q1 [$];
   logic [15:0] exp_cnt;

   // Parity of d(x)*x^4 mod g(x) by serial long division.
   function automatic logic [3:0] enc_par(input logic [10:0] d);
      logic [3:0] rem;
      logic fb;
      rem = 4'b0000;
      for (int i = 10; i >= 0; i--) begin
         fb  = d[i] ^ rem[3];
         rem = {rem[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return rem;
   endfunction

   function automatic logic [3:0] model_syn(input logic [14:0] r);
      logic [3:0] s;
      s = 4'b0000;
      for (int i = 0; i < 15; i++)
         if (r[i]) s = s ^ pow_tab[i];
      return s;
   endfunction

   task automatic push_expect(input logic [14:0] r);
      logic [3:0]  syn;
      logic [3:0]  pos;
      logic [14:0] corr;
      syn  = model_syn(r);
      pos  = 4'd0;
      corr = r;
      if (syn != 4'b0000) begin
         for (int i = 0; i < 15; i++)
            if (pow_tab[i] == syn) pos = 4'(i);
         corr = r ^ (15'd1 << pos);
         if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
      end
      for (int i = 14; i >= 4; i--) exp_q0.push_back({(i == 4), corr[i]});
      for (int i = 14; i >= 0; i--) exp_q1.push_back({(i == 0), corr[i]});
      st_q0.push_back({(syn != 4'b0000), pos, exp_cnt});
      st_q1.push_back({(syn != 4'b0000), pos, exp_cnt});
   endtask

   task automatic flush_model();
      exp_q0.delete();
      exp_q1.delete();
      st_q0.delete();
      st_q1.delete();
      exp_cnt = 16'd0;
   endtask

   task automatic idle(input int n);
      bus0.in_valid = 1'b0;
      bus0.in_bit   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Drives one 15-bit word MSB first starting at a negedge; gap_max > 0 inserts random idle cycles.
   task automatic send_word(input logic [14:0] r, input int gap_max);
      for (int i = 14; i >= 0; i--) begin
         if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, gap_max)) begin
               bus0.in_valid = 1'b0;
               bus0.in_bit   = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
         end
         bus0.in_valid = 1'b1;
         bus0.in_bit   = r[i];
         if (i == 0) push_expect(r);
         @(negedge clk);
      end
      bus0.in_valid = 1'b0;
      bus0.in_bit   = 1'b0;
      checks++;
      if ({bus0.blk_done, bus0.out_valid, bus1.blk_done, bus1.out_valid} !== 4'b1111) begin
         errors++;
         $display("FAIL blk_done_timing: got done/valid dut0=%b%b dut1=%b%b want 1111",
                  bus0.blk_done, bus0.out_valid, bus1.blk_done, bus1.out_valid);
      end
   endtask

   // Scoreboard: pops on every shown output bit and on every blk_done pulse.
   always @(posedge clk) begin
      logic [1:0]  e;
      logic [20:0] s;
      #1;
      if (reset) begin
         run1 = 0;
      end else begin
         if (bus0.out_valid) begin
            checks++;
            if (exp_q0.size() == 0) begin
               errors++;
               $display("FAIL out0_unexpected: got bit %b with empty expectation", bus0.out_bit);
            end else begin
               e = exp_q0.pop_front();
               if ({bus0.out_last, bus0.out_bit} !== e) begin
                  errors++;
                  $display("FAIL out0_bit: got last/bit %b%b want %b", bus0.out_last, bus0.out_bit, e);
               end
            end
         end
         if (bus1.out_valid) begin
            checks++;
            run1++;
            if (run1 > max_run1) max_run1 = run1;
            if (exp_q1.size() == 0) begin
               errors++;
               $display("FAIL out1_unexpected: got bit %b with empty expectation", bus1.out_bit);
            end else begin
               e = exp_q1.pop_front();
               if ({bus1.out_last, bus1.out_bit} !== e) begin
                  errors++;
                  $display("FAIL out1_bit: got last/bit %b%b want %b", bus1.out_last, bus1.out_bit, e);
               end
            end
         end else begin
            run1 = 0;
         end
         if (bus0.blk_done) begin
            checks++;
            if (st_q0.size() == 0) begin
               errors++;
               $display("FAIL status0_unexpected: blk_done with no block pending");
            end else begin
               s = st_q0.pop_front();
               if ({bus0.err_flag, bus0.err_pos, bus0.err_count} !== s) begin
                  errors++;
                  $display("FAIL status0: got flag/pos/cnt %b/%0d/%0d want %b/%0d/%0d",
                           bus0.err_flag, bus0.err_pos, bus0.err_count, s[20], s[19:16], s[15:0]);
               end
            end
         end
         if (bus1.blk_done) begin
            checks++;
            if (st_q1.size() == 0) begin
               errors++;
               $display("FAIL status1_unexpected: blk_done with no block pending");
            end else begin
               s = st_q1.pop_front();
               if ({bus1.err_flag, bus1.err_pos, bus1.err_count} !== s) begin
                  errors++;
                  $display("FAIL status1: got flag/pos/cnt %b/%0d/%0d want %b/%0d/%0d",
                           bus1.err_flag, bus1.err_pos, bus1.err_count, s[20], s[19:16], s[15:0]);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      bus0.in_valid = 1'b0;
      bus0.in_bit   = 1'b0;
      flush_model();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus0.out_valid, bus0.out_bit, bus0.out_last, bus0.blk_done, bus0.err_flag,
           bus0.err_pos, bus0.err_count, bus1.out_valid, bus1.out_bit, bus1.out_last,
           bus1.blk_done, bus1.err_flag, bus1.err_pos, bus1.err_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nonzero outputs dut0 v=%b cnt=%0d dut1 v=%b cnt=%0d, want all 0",
                  bus0.out_valid, bus0.err_count, bus1.out_valid, bus1.err_count);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_word();
      send_word(15'd0, 0);
      checks++;
      if ({bus0.err_flag, bus0.err_pos, bus0.err_count} !== 21'd0) begin
         errors++;
         $display("FAIL zero_status: got flag=%b pos=%0d cnt=%0d want 0/0/0",
                  bus0.err_flag, bus0.err_pos, bus0.err_count);
      end
      idle(16);
   endtask

   task automatic test_clean_msb();
      send_word(15'b100000000001001, 0);
      checks++;
      if ({bus0.err_flag, bus0.err_pos} !== 5'd0) begin
         errors++;
         $display("FAIL clean_msb_status: got flag=%b pos=%0d want 0/0", bus0.err_flag, bus0.err_pos);
      end
      idle(16);
   endtask

   task automatic test_msb_flip();
      send_word(15'b000000000001001, 0);
      checks++;
      if ({bus0.err_flag, bus0.err_pos, bus0.err_count} !== {1'b1, 4'd14, 16'd1}) begin
         errors++;
         $display("FAIL msb_flip_status: got flag=%b pos=%0d cnt=%0d want 1/14/1",
                  bus0.err_flag, bus0.err_pos, bus0.err_count);
      end
      idle(16);
   endtask

   task automatic test_parity_err();
      send_word(15'b000000000000001, 0);
      checks++;
      if ({bus1.err_flag, bus1.err_pos, bus1.err_count} !== {1'b1, 4'd0, 16'd2}) begin
         errors++;
         $display("FAIL parity_err_status: got flag=%b pos=%0d cnt=%0d want 1/0/2",
                  bus1.err_flag, bus1.err_pos, bus1.err_count);
      end
      idle(18);
   endtask

   task automatic test_double_err();
      send_word(15'b110000000000000, 0);
      checks++;
      if ({bus1.err_flag, bus1.err_pos, bus1.err_count} !== {1'b1, 4'd2, 16'd3}) begin
         errors++;
         $display("FAIL double_err_status: got flag=%b pos=%0d cnt=%0d want 1/2/3",
                  bus1.err_flag, bus1.err_pos, bus1.err_count);
      end
      idle(18);
   endtask

   task automatic test_reset_mid();
      send_word(15'b100000000001001, 0);
      for (int i = 0; i < 7; i++) begin
         bus0.in_valid = 1'b1;
         bus0.in_bit   = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      reset = 1'b1;
      bus0.in_valid = 1'b0;
      flush_model();
      @(negedge clk);
      checks++;
      if ({bus0.out_valid, bus0.err_flag, bus0.err_count, bus1.out_valid, bus1.out_bit,
           bus1.out_last, bus1.blk_done} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got dut0 v=%b cnt=%0d dut1 v=%b, want all 0",
                  bus0.out_valid, bus0.err_count, bus1.out_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      send_word(15'b100000000001001, 0);
      checks++;
      if ({bus0.err_flag, bus0.err_count} !== 17'd0) begin
         errors++;
         $display("FAIL reset_mid_clean: got flag=%b cnt=%0d want 0/0", bus0.err_flag, bus0.err_count);
      end
      idle(18);
   endtask

   task automatic test_back_to_back();
      logic [10:0] d;
      idle(4);
      max_run1 = 0;
      for (int b = 0; b < 3; b++) begin
         d = 11'($urandom_range(0, 2047));
         send_word({d, enc_par(d)}, 0);
      end
      idle(20);
      checks++;
      if (max_run1 != 45) begin
         errors++;
         $display("FAIL back_to_back_valid_run: got %0d consecutive out_valid cycles want 45", max_run1);
      end
   endtask

   task automatic test_random();
      logic [10:0] d;
      logic [14:0] cw;
      int inj;
      reset = 1'b1;
      flush_model();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      inj = 0;
      for (int b = 0; b < 1000; b++) begin
         d  = 11'($urandom_range(0, 2047));
         cw = {d, enc_par(d)};
         if ($urandom_range(0, 1) == 1) begin
            cw = cw ^ (15'd1 << $urandom_range(0, 14));
            inj++;
         end
         send_word(cw, 3);
      end
      idle(20);
      checks++;
      if (bus0.err_count !== 16'(inj) || bus1.err_count !== 16'(inj)) begin
         errors++;
         $display("FAIL random_err_count: got dut0=%0d dut1=%0d want %0d",
                  bus0.err_count, bus1.err_count, inj);
      end
   endtask

   task automatic test_drain();
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0 || st_q0.size() != 0 || st_q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got pending bits %0d/%0d status %0d/%0d want all 0",
                  exp_q0.size(), exp_q1.size(), st_q0.size(), st_q1.size());
      end
   endtask

   initial begin
      pow_tab[0] = 4'b0001;
      for (int i = 1; i < 15; i++)
         pow_tab[i] = {pow_tab[i-1][2:0], 1'b0} ^ (pow_tab[i-1][3] ? 4'b0011 : 4'b0000);
      exp_cnt = 16'd0;
      bus0.in_valid = 1'b0;
      bus0.in_bit   = 1'b0;
      @(negedge clk);
      test_reset();
      test_zero_word();
      test_clean_msb();
      test_msb_flip();
      test_parity_err();
      test_double_err();
      test_drain();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cyclic_decoder_systematic.md
# cyclic_decoder_systematic

Serial decoder for the systematic (15,11) cyclic Hamming code with generator g(x) = x^4 + x + 1. It receives codewords one bit per accepted cycle, computes the 4-bit syndrome on the fly, and corrects any single-bit error through a syndrome-to-position lookup. It then shifts out the 11 corrected data bits, or all 15 bits when configured to. It sits at the receive end of the link, opposite the systematic cyclic coder.

## Interface
- OUT_PARITY, default 0: 0 = output 11 data bits per block; 1 = output full corrected 15-bit codeword.
- ERRCNT_W, default 16: width of corrected-error counter.

- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  in_bit is accepted on this edge.
- in_bit  in  1  received code bit, codeword MSB (c[14]) first.
- out_valid  out  1  out_bit holds a decoded bit.
- out_bit  out  1  decoded bit, MSB first.
- out_last  out  1  high with the final out_bit of a block.
- blk_done  out  1  one-cycle pulse: block decoded, status updated.
- err_flag  out  1  syndrome of the last block was nonzero; held until the next blk_done.
- err_pos  out  4  corrected bit index 0..14 of the last block; 0 when err_flag = 0.
- err_count  out  ERRCNT_W  number of blocks with nonzero syndrome, saturating.

## Operation
- Codeword layout: c[14:4] = d[10:0], c[3:0] = (d(x)·x^4) mod g(x). Bits travel c[14] first.
- RX side:
  - 4-bit bit counter rx_cnt, 0..14, advances only on in_valid.
  - 15-bit receive shift register.
  - Syndrome register s, updated per accepted bit as s_next = {s[2:0], in_bit} ^ (s[3] ? 4'b0011 : 4'b0000).
- After 15 bits, s = r(x) mod g(x). Syndrome-to-position table, s = x^i mod g:
  - 0001→0, 0010→1, 0100→2, 1000→3, 0011→4, 0110→5, 1100→6, 1011→7
  - 0101→8, 1010→9, 0111→10, 1110→11, 1111→12, 1101→13, 1001→14
  - s = 0000 means no error.
- Block completion: on the edge accepting the bit with rx_cnt = 14, using the combinational s_next and buffer_next:
  - the corrected word (received word XOR one-hot at err_pos) loads into the TX shift register;
  - err_flag, err_pos and err_count update;
  - rx_cnt and s clear to 0.
- TX side:
  - A TX counter emits 11 bits (OUT_PARITY = 0: c[14]..c[4]) or 15 bits (OUT_PARITY = 1: c[14]..c[0]), one per cycle, unconditionally; there is no backpressure.
- Double errors alias to a valid syndrome and are miscorrected. This is inherent to a perfect code and is not flagged.
- err_count increments when err_flag is set and stops at all-ones.
- Reset values:
  - out_valid, out_bit, out_last, blk_done, err_flag = 0; err_pos = 0; err_count = 0.
  - rx_cnt = 0; s = 0; buffers = 0.
- Reset mid-block discards the partial RX block and any TX block in progress.

## Timing
- Edge E accepts the 15th bit. In the cycle after E:
  - blk_done = 1;
  - out_valid = 1 with the first bit (c[14]);
  - err_flag, err_pos and err_count show the new values.
- Output runs on consecutive cycles E+1..E+11, or E+15 when OUT_PARITY = 1. out_last is high in the final cycle.
- The next block cannot complete before E+15, so TX never overruns.
  - Block N+1's load may occur in the same cycle that block N's last output bit is shown; the load takes effect the following cycle.
  - With back-to-back input and OUT_PARITY = 1, out_valid stays continuously high.
- Gaps in in_valid stall RX only; TX continues independently.
- in_bit is ignored when in_valid = 0.

## Test plan
- Zero codeword: 15 zeros, in_valid held high → 11 zero out_bits; err_flag = 0; blk_done pulse one cycle after the 15th bit; out_last on the 11th bit.
- d = 11'b10000000000 → send 15'b100000000001001 → out 1 followed by ten 0s; err_flag = 0; err_pos = 0.
- Same word with c[14] flipped (15'b000000000001001) → syndrome 1001; err_pos = 14; err_flag = 1; out 10000000000; err_count = 1.
- Parity error: flip c[0] of the zero codeword → err_pos = 0; data out all zeros; with OUT_PARITY = 1, all 15 out bits are 0.
- Double error: flip c[14] and c[13] of the zero codeword → syndrome 0100; err_pos = 2; output c[2] = 1 when OUT_PARITY = 1 (the documented miscorrection).
- Reset and flow:
  - Assert reset after 7 input bits, then send a clean block → only the clean block is decoded; all outputs are 0 during reset.
  - Random in_valid gaps across 1000 random blocks with 0 or 1 injected errors → data matches the model; err_count equals the number of injected errors.
